pes_fp_mul_pipe: RTL and testbench
==================================

# pes_fp_mul_pipe

Parametrised, fully pipelined IEEE-754-style floating-point multiplier with valid/ready flow control. It is the successor to the team's fixed FP32 three-stage multiplier and replaces it in the arithmetic datapath. It adds:
- configurable exponent/mantissa widths
- hidden-bit normalisation
- rounding
- special-value handling, exception flags and backpressure

## Interface
Parameters:
- EXP_W, 8, exponent field width (≥3); BIAS = 2^(EXP_W-1)-1
- MAN_W, 23, stored mantissa width (≥2); word width W = 1+EXP_W+MAN_W

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low
- in_valid  input  1  operand pair a/b valid
- in_ready  output  1  block accepts a/b this cycle
- a  input  W  operand A {sign, exp, man}
- b  input  W  operand B
- out_valid  output  1  f/flags valid
- out_ready  input  1  downstream accepts f this cycle
- f  output  W  product
- flags  output  4  {nv, of, uf, nx}: invalid, overflow, underflow, inexact

## Operation
- Pipeline stages:
  - S1 unpack/classify (zero, inf, NaN, normal); sign = a[W-1]^b[W-1]; exponent sum ea+eb-BIAS in EXP_W+2-bit signed.
  - S2 (1.ma)×(1.mb), 2·(MAN_W+1)-bit product.
  - S3 normalise, round, range-check, pack.
- Subnormal inputs are treated as zero of the same sign (flush-to-zero). Subnormal results are never produced.
- Normalise: product in [1,4). If top bit set, shift right 1 and add 1 to exponent.
- Guard = first dropped bit. Sticky = OR of the remaining dropped bits. nx = guard|sticky.
- Rounding (see Configuration): a mantissa carry-out sets mantissa 0 and adds 1 to exponent, re-checked for overflow.
- Range check on the biased exponent:
  - ≥ 2^EXP_W-1 → ±inf, of=1, nx=1.
  - ≤ 0 → ±0, uf=1, nx=1.
- Special cases (S1 decides; S2/S3 pass through):
  - Either input NaN → canonical qNaN (sign 0, exp all ones, man MSB 1, rest 0), flags 0.
  - inf × 0 → canonical qNaN, nv=1.
  - inf × nonzero → ±inf, flags 0.
  - zero × finite → ±0, flags 0.
- Flow control: one global advance enable, en = out_ready | ~out_valid.
  - in_ready = en. A transfer occurs when in_valid & in_ready.
  - Each stage carries a valid bit. Bubbles propagate as invalid slots; they are not collapsed.
- While out_valid & ~out_ready, f/flags and all stage registers hold. Results are never dropped or reordered.

## Timing
- Latency 3 cycles: an operand accepted at edge N gives out_valid=1 with its result after edge N+3, provided out_ready stays high.
- Throughput 1 result/cycle with out_ready held high.
- in_ready is combinational from out_ready and out_valid only. There is no path from in_valid.
- Reset (rst low at an edge): all stage valids 0, out_valid 0, f 0, flags 0. In-flight operations are discarded.
  - in_ready = 1 during and after reset (out_valid = 0).
  - Reset asserted mid-stall clears the pipeline. No result is emitted for pre-reset inputs.
- Simultaneous output handshake and new input on the same edge: both complete; the pipeline shifts by one.
- in_valid=0 while en=1 inserts a bubble; out_valid drops 3 cycles later for one cycle.

## Configuration
- Macro PES_FPMUL_RNE_EN.
- Defined: round-to-nearest-even. Increment when guard & (sticky | lsb).
- Undefined: truncation (round toward zero); no increment. Overflow still yields ±inf with of=1.
- nx is computed identically in both modes.

## Test plan
- EXP_W=8, MAN_W=23: a=0x40400000 (3.0), b=0x40000000 (2.0), out_ready=1 → f=0x40C00000, flags=0, out_valid exactly 3 cycles after accept.
- a=0xBFC00000, b=0x3FC00000 → f=0xC0100000 (-2.25), flags=0. Also a back-to-back stream of 8 pairs → 8 consecutive out_valid cycles, in order.
- a=b=0x7F000000 → f=0x7F800000, flags of=1, nx=1. a=b=0x00800000 → f=0x00000000, uf=1, nx=1.
- a=0x7F800000 (inf), b=0x00000000 → f=0x7FC00000, nv=1. a=0x7FC00000, b=0x3F800000 → f=0x7FC00000, flags=0.
- a=0x3F800001, b=0x3FC00000 → f=0x3FC00002 with PES_FPMUL_RNE_EN, 0x3FC00001 without; nx=1 in both.
- Issue 4 ops, hold out_ready=0 for 5 cycles once out_valid rises → in_ready=0, f stable. Release → 4 results in order, none lost. Assert rst low mid-stall → out_valid=0 next cycle, no stale results afterward.

Source files
------------

// File: rtl/pes_fp_mul_pipe.sv
// Pipelined floating-point multiplier with valid/ready flow control and flush-to-zero.
// Define PES_FPMUL_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module pes_fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] f,
  output logic [3:0]           flags
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * (MAN_W + 1);
  localparam logic [EW-1:0]        BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_MIN = '0;
  localparam logic [W-1:0]         QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic en;
  logic v1_q, v2_q, v3_q, out_valid_q;
  logic [W-1:0] f_d, f_q;
  logic [3:0]   flags_d, flags_q;

  // The whole pipeline advances together; a stalled output freezes every stage.
  assign en        = out_ready | ~out_valid_q;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign flags     = flags_q;

  // S1: unpack, classify, resolve special operands, sum exponents.
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic spec1_d, sign1_d;
  logic [W-1:0] spec_f1_d;
  logic [3:0]   spec_fl1_d;
  logic signed [EW-1:0] exp1_d;

  assign {ea, ma} = a[W-2:0];
  assign {eb, mb} = b[W-2:0];
  assign a_zero   = (ea == '0);
  assign b_zero   = (eb == '0);
  assign a_nan    = (&ea) & (|ma);
  assign b_nan    = (&eb) & (|mb);
  assign a_inf    = (&ea) & ~(|ma);
  assign b_inf    = (&eb) & ~(|mb);
  assign sign1_d  = a[W-1] ^ b[W-1];
  assign exp1_d   = {2'b00, ea} + {2'b00, eb} - BIAS;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    spec1_d    = 1'b1;
    spec_f1_d  = QNAN;
    spec_fl1_d = 4'b0000;
    if (a_nan | b_nan) begin
      spec_fl1_d = 4'b0000;
    end else if ((a_inf & b_zero) | (b_inf & a_zero)) begin
      spec_fl1_d = 4'b1000;
    end else if (a_inf | b_inf) begin
      spec_f1_d = {sign1_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero | b_zero) begin
      spec_f1_d = {sign1_d, {(EXP_W+MAN_W){1'b0}}};
    end else begin
      spec1_d = 1'b0;
    end
  end

  logic spec1_q, sign1_q;
  logic [W-1:0] spec_f1_q;
  logic [3:0]   spec_fl1_q;
  logic signed [EW-1:0] exp1_q;
  logic [MAN_W-1:0] ma1_q, mb1_q;

  // S2: significand product with hidden bits restored.
  logic [PW-1:0] prod2_d, prod2_q;
  logic spec2_q, sign2_q;
  logic [W-1:0] spec_f2_q;
  logic [3:0]   spec_fl2_q;
  logic signed [EW-1:0] exp2_q;

  assign prod2_d = PW'({1'b1, ma1_q}) * PW'({1'b1, mb1_q});

  // S3: normalise from [1,4) to [1,2), then round.
  logic hi, guard, sticky, inc, carry, nx3_d;
  logic [MAN_W-1:0] man_t, man3_d;
  logic signed [EW-1:0] exp3_d;

  always_comb begin
    hi = prod2_q[PW-1];
    if (hi) begin
      man_t  = prod2_q[PW-2 -: MAN_W];
      guard  = prod2_q[PW-2-MAN_W];
      sticky = |prod2_q[PW-3-MAN_W:0];
    end else begin
      man_t  = prod2_q[PW-3 -: MAN_W];
      guard  = prod2_q[PW-3-MAN_W];
      sticky = |prod2_q[PW-4-MAN_W:0];
    end
`ifdef PES_FPMUL_RNE_EN
    inc = guard & (sticky | man_t[0]);
`else
    inc = 1'b0;
`endif
    {carry, man3_d} = {1'b0, man_t} + {{MAN_W{1'b0}}, inc};
    exp3_d = exp2_q + EW'(hi) + EW'(carry);
    nx3_d  = guard | sticky;
  end

  logic spec3_q, sign3_q, nx3_q;
  logic [W-1:0] spec_f3_q;
  logic [3:0]   spec_fl3_q;
  logic signed [EW-1:0] exp3_q;
  logic [MAN_W-1:0] man3_q;

  // Output: range check on the rounded biased exponent, then pack.
  always_comb begin
    f_d     = {sign3_q, exp3_q[EXP_W-1:0], man3_q};
    flags_d = {3'b000, nx3_q};
    if (spec3_q) begin
      f_d     = spec_f3_q;
      flags_d = spec_fl3_q;
    end else if (exp3_q >= EXP_MAX) begin
      f_d     = {sign3_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d = 4'b0101;
    end else if (exp3_q <= EXP_MIN) begin
      f_d     = {sign3_q, {(EXP_W+MAN_W){1'b0}}};
      flags_d = 4'b0011;
    end
  end

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      f_q         <= '0;
      flags_q     <= '0;
    end else if (en) begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      out_valid_q <= v3_q;
      f_q         <= f_d;
      flags_q     <= flags_d;
    end
  end

  // NOTE: datapath registers carry no reset; the stage valid bits alone decide what is meaningful.
  always_ff @(posedge clk) begin
    if (en) begin
      spec1_q    <= spec1_d;
      sign1_q    <= sign1_d;
      spec_f1_q  <= spec_f1_d;
      spec_fl1_q <= spec_fl1_d;
      exp1_q     <= exp1_d;
      ma1_q      <= ma;
      mb1_q      <= mb;

      spec2_q    <= spec1_q;
      sign2_q    <= sign1_q;
      spec_f2_q  <= spec_f1_q;
      spec_fl2_q <= spec_fl1_q;
      exp2_q     <= exp1_q;
      prod2_q    <= prod2_d;

      spec3_q    <= spec2_q;
      sign3_q    <= sign2_q;
      spec_f3_q  <= spec_f2_q;
      spec_fl3_q <= spec_fl2_q;
      exp3_q     <= exp3_d;
      man3_q     <= man3_d;
      nx3_q      <= nx3_d;
    end
  end
endmodule

// File: tb/tb_pes_fp_mul_pipe.sv
// Self-checking bench for pes_fp_mul_pipe (FP32 configuration) against an integer reference model.
// Honours PES_FPMUL_RNE_EN the same way as the design.
module tb_pes_fp_mul_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] f;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;
  logic [35:0] exp_q[$];

  pes_fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  // Reference: exact integer significand product, remainder-based rounding, range check.
  function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    int ex, ey, e, sh;
    longint unsigned mx, my, sig, q, rem, half;
    logic s, nx;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = 64'(x[22:0]);
    my = 64'(y[22:0]);
    s  = x[31] ^ y[31];
    if ((ex == 255 && mx != 0) || (ey == 255 && my != 0)) return {4'b0000, 32'h7FC00000};
    if ((ex == 255 && ey == 0) || (ey == 255 && ex == 0)) return {4'b1000, 32'h7FC00000};
    if (ex == 255 || ey == 255) return {4'b0000, s, 8'hFF, 23'h0};
    if (ex == 0 || ey == 0) return {4'b0000, s, 31'h0};
    sig = (mx + (64'd1 << 23)) * (my + (64'd1 << 23));
    e = ex + ey - 127;
    if (sig >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    q    = sig >> sh;
    rem  = sig - (q << sh);
    half = 64'd1 << (sh - 1);
    nx   = (rem != 0);
`ifdef PES_FPMUL_RNE_EN
    if (rem > half || (rem == half && q[0])) q = q + 1;
`endif
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
    if (e <= 0) return {4'b0011, s, 31'h0};
    return {3'b000, nx, s, 8'(e), 23'(q)};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) != 0) r[30:23] = 8'($urandom_range(90, 165));
    return r;
  endfunction

  // Drives one cycle from just after a falling edge; samples before the rising edge.
  task automatic drive_cycle(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                             input logic ordy, output logic acc, output logic fire,
                             output logic [35:0] got);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    out_ready = ordy;
    #1;
    acc  = in_valid && in_ready;
    fire = out_valid && out_ready;
    got  = {flags, f};
    if (acc) exp_q.push_back(ref_mul(ia, ib));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst       = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (f !== 32'h0) begin n_fail++; $display("FAIL reset_f: got %h expected 00000000", f); end
    n_checks++;
    if (flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", flags); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    exp_q.delete();
  endtask

  task automatic test_directed;
`ifdef PES_FPMUL_RNE_EN
    localparam logic [31:0] RND_F = 32'h3FC00002;
`else
    localparam logic [31:0] RND_F = 32'h3FC00001;
`endif
    logic [31:0] va[10], vb[10], vf[10];
    logic [3:0]  vfl[10];
    logic acc, fire;
    logic [35:0] got, expv;
    int lat;
    va  = '{32'h40400000, 32'hBFC00000, 32'h7F000000, 32'h00800000, 32'h7F800000,
            32'h7FC00000, 32'h3F800001, 32'h80000000, 32'hFF800000, 32'h00000001};
    vb  = '{32'h40000000, 32'h3FC00000, 32'h7F000000, 32'h00800000, 32'h00000000,
            32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h40000000, 32'h3F800000};
    vf  = '{32'h40C00000, 32'hC0100000, 32'h7F800000, 32'h00000000, 32'h7FC00000,
            32'h7FC00000, RND_F,        32'h80000000, 32'hFF800000, 32'h00000000};
    vfl = '{4'b0000, 4'b0000, 4'b0101, 4'b0011, 4'b1000,
            4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, va[i], vb[i], 1'b1, acc, fire, got);
      n_checks++;
      if (acc !== 1'b1) begin n_fail++; $display("FAIL directed_accept[%0d]: got %b expected 1", i, acc); end
      lat = -1;
      for (int k = 0; k < 10 && lat < 0; k++) begin
        drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, acc, fire, got);
        if (fire) lat = k;
      end
      n_checks++;
      if (lat != 3) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d edges expected 3", i, lat);
      end
      if (lat >= 0) begin
        n_checks++;
        if (got !== {vfl[i], vf[i]}) begin
          n_fail++;
          $display("FAIL directed_value[%0d]: got f=%h flags=%b expected f=%h flags=%b",
                   i, got[31:0], got[35:32], vf[i], vfl[i]);
        end
        if (exp_q.size() > 0) begin
          expv = exp_q.pop_front();
          n_checks++;
          if (got !== expv) begin
            n_fail++;
            $display("FAIL directed_model[%0d]: got %h expected %h", i, got, expv);
          end
        end
      end
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back;
    logic acc, fire;
    logic [35:0] got, expv;
    logic [31:0] xa, xb;
    int first, last, cnt;
    first = -1; last = -1; cnt = 0;
    for (int c = 0; c < 24; c++) begin
      xa = (c == 0) ? 32'hBFC00000 : rand_op();
      xb = (c == 0) ? 32'h3FC00000 : rand_op();
      drive_cycle(c < 8, xa, xb, 1'b1, acc, fire, got);
      if (fire) begin
        if (first < 0) first = c;
        last = c;
        cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra: got %h expected no output", got);
        end else begin
          expv = exp_q.pop_front();
          if (got !== expv) begin n_fail++; $display("FAIL b2b_value: got %h expected %h", got, expv); end
        end
      end
    end
    n_checks++;
    if (cnt != 8) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", cnt); end
    n_checks++;
    if (last - first != 7) begin n_fail++; $display("FAIL b2b_consecutive: got span %0d expected 7", last - first); end
    exp_q.delete();
  endtask

  task automatic test_bubble;
    logic acc, fire;
    logic [35:0] got, expv;
    int fc[$];
    for (int c = 0; c < 12; c++) begin
      drive_cycle(c == 0 || c == 2, rand_op(), rand_op(), 1'b1, acc, fire, got);
      if (fire) begin
        fc.push_back(c);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bubble_extra: got %h expected no output", got);
        end else begin
          expv = exp_q.pop_front();
          if (got !== expv) begin n_fail++; $display("FAIL bubble_value: got %h expected %h", got, expv); end
        end
      end
    end
    n_checks++;
    if (fc.size() != 2) begin
      n_fail++;
      $display("FAIL bubble_count: got %0d expected 2", fc.size());
    end else if (fc[1] - fc[0] != 2) begin
      n_fail++;
      $display("FAIL bubble_gap: got %0d expected 2", fc[1] - fc[0]);
    end
    exp_q.delete();
  endtask

  task automatic test_stall;
    logic acc, fire;
    logic [35:0] got, expv;
    int cnt;
    for (int c = 0; c < 4; c++) begin
      drive_cycle(1'b1, rand_op(), rand_op(), 1'b0, acc, fire, got);
      n_checks++;
      if (acc !== 1'b1) begin n_fail++; $display("FAIL stall_fill_accept[%0d]: got %b expected 1", c, acc); end
    end
    for (int c = 0; c < 5; c++) begin
      drive_cycle(1'b1, rand_op(), rand_op(), 1'b0, acc, fire, got);
      n_checks++;
      if (acc !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got accept %b expected 0", c, acc); end
      n_checks++;
      if (got[31:0] !== exp_q[0][31:0] || got[35:32] !== exp_q[0][35:32] || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got %h valid %b expected %h valid 1", c, got, out_valid, exp_q[0]);
      end
    end
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, acc, fire, got);
      if (fire) begin
        cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stall_extra: got %h expected no output", got);
        end else begin
          expv = exp_q.pop_front();
          if (got !== expv) begin n_fail++; $display("FAIL stall_release: got %h expected %h", got, expv); end
        end
      end
    end
    n_checks++;
    if (cnt != 4) begin n_fail++; $display("FAIL stall_count: got %0d expected 4", cnt); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_stall;
    logic acc, fire;
    logic [35:0] got;
    int cnt;
    for (int c = 0; c < 3; c++) drive_cycle(1'b1, rand_op(), rand_op(), 1'b0, acc, fire, got);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, acc, fire, got);
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midstall_setup: got valid %b ready %b expected valid 1 ready 0", out_valid, in_ready);
    end
    rst = 1'b0;
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, acc, fire, got);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || f !== 32'h0 || flags !== 4'h0) begin
      n_fail++;
      $display("FAIL midstall_reset: got valid %b ready %b f %h flags %b expected 0 1 00000000 0000",
               out_valid, in_ready, f, flags);
    end
    rst = 1'b1;
    exp_q.delete();
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      drive_cycle(1'b0, 32'h0, 32'h0, 1'b1, acc, fire, got);
      if (fire) cnt++;
    end
    n_checks++;
    if (cnt != 0) begin n_fail++; $display("FAIL midstall_stale: got %0d outputs expected 0", cnt); end
  endtask

  task automatic test_random_flow;
    logic acc, fire;
    logic [35:0] got, expv;
    for (int c = 0; c < 320; c++) begin
      drive_cycle(c < 300 && $urandom_range(0, 9) < 7, rand_op(), rand_op(),
                  c >= 300 || $urandom_range(0, 9) < 7, acc, fire, got);
      if (fire) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL random_extra: got %h expected no output", got);
        end else begin
          expv = exp_q.pop_front();
          if (got !== expv) begin n_fail++; $display("FAIL random_value: got %h expected %h", got, expv); end
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: got %0d results missing expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_bubble();
    test_stall();
    test_reset_mid_stall();
    test_random_flow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
